// File: rtl/bus_load_sequencer.sv
// Queued bus transfer controller: selects a source on the shared bus, then pulses the destination load enable.
// Optional capture of the loaded bus value is built when BUS_SNOOP_EN is defined.
module bus_load_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_src,
    input  logic [4:0]  req_dst,
    output logic [4:0]  EnOut,
    input  logic [31:0] bus_in,
    output logic [23:0] load_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] snoop_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0] MAX_CODE = 5'd23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        LOAD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       src_mem_q [FIFO_DEPTH];
    logic [4:0]       src_mem_d [FIFO_DEPTH];
    logic [4:0]       dst_mem_q [FIFO_DEPTH];
    logic [4:0]       dst_mem_d [FIFO_DEPTH];
    logic [4:0]       cur_src_q, cur_src_d;
    logic [4:0]       cur_dst_q, cur_dst_d;
    logic [4:0]       en_out_q, en_out_d;
    logic [23:0]      load_en_q, load_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept, code_ok, push, pop;

    assign req_ready = (count_q != FULL_CNT);
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign EnOut     = en_out_q;
    assign load_en   = load_en_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        accept  = req_valid && req_ready;
        code_ok = (req_src <= MAX_CODE) && (req_dst <= MAX_CODE);
        push    = accept && code_ok;
        pop     = ((state_q == IDLE) || (state_q == LOAD)) && (count_q != '0);

        src_mem_d = src_mem_q;
        dst_mem_d = dst_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            src_mem_d[wr_ptr_q] = req_src;
            dst_mem_d[wr_ptr_q] = req_dst;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q || (accept && !code_ok);

        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        if (pop) begin
            cur_src_d = src_mem_q[rd_ptr_q];
            cur_dst_d = dst_mem_q[rd_ptr_q];
        end
        case (state_q)
            IDLE:    state_d = pop ? SELECT : IDLE;
            SELECT:  state_d = LOAD;
            LOAD:    state_d = pop ? SELECT : IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so they come straight out of flops.
        en_out_d  = (state_d == IDLE) ? 5'b11111 : cur_src_d;
        load_en_d = (state_d == LOAD) ? (24'd1 << cur_dst_d) : '0;
        done_d    = (state_d == LOAD);
    end

    always_ff @(posedge clock) begin
        src_mem_q <= src_mem_d;
        dst_mem_q <= dst_mem_d;
        if (!clear) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            en_out_q  <= '1;
            load_en_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            en_out_q  <= en_out_d;
            load_en_q <= load_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef BUS_SNOOP_EN
    logic [31:0] snoop_q, snoop_d;

    always_comb begin
        snoop_d = (state_q == LOAD) ? bus_in : snoop_q;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            snoop_q <= '0;
        end else begin
            snoop_q <= snoop_d;
        end
    end

    assign snoop_data = snoop_q;
`else
    logic unused_bus_in;
    assign unused_bus_in = ^bus_in;
    assign snoop_data    = '0;
`endif

endmodule

// File: tb/tb_bus_load_sequencer.sv
// Bench for bus_load_sequencer: directed and random requests checked every cycle against a transfer-level model.
module tb_bus_load_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic [4:0]  req_src = '0;
    logic [4:0]  req_dst = '0;
    logic        req_ready;
    logic [4:0]  EnOut;
    logic [31:0] bus_in;
    logic [23:0] load_en;
    logic        busy, done, err;
    logic [31:0] snoop_data;

    always #5 clock = ~clock;

    // Register file contents seen through the bus multiplexer; code 31 floats the bus high.
    function automatic logic [31:0] reg_val(input logic [4:0] c);
        if (c == 5'd31) return 32'hFFFF_FFFF;
        if (c == 5'd5)  return 32'hDEAD_BEEF;
        return {8'hB0, 19'd0, c};
    endfunction

    assign bus_in = reg_val(EnOut);

    bus_load_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .EnOut      (EnOut),
        .bus_in     (bus_in),
        .load_en    (load_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .snoop_data (snoop_data)
    );

    // Each pending transfer carries the edge number after which its load pulse is due.
    typedef struct {
        logic [4:0] src;
        logic [4:0] dst;
        int         due;
    } xfer_t;

    xfer_t       exp_q[$];
    int          cyc = 0;
    int          last_due = -100;
    int          checks = 0;
    int          errors = 0;
    logic        exp_err = 1'b0;
    logic        exp_ready = 1'b1;
    logic [31:0] exp_snoop = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic fail_bound(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected completion (edge %0d)", tag, cyc);
    endtask

    task automatic monitor();
        int          in_fifo;
        logic [4:0]  exp_en;
        logic [23:0] exp_le;
        logic        exp_done;
        in_fifo  = 0;
        exp_en   = 5'h1F;
        exp_le   = '0;
        exp_done = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].due > cyc + 1) in_fifo++;
        exp_ready = (in_fifo != int'(DEPTH));
        if (exp_q.size() != 0 && exp_q[0].due <= cyc + 1) begin
            exp_en = exp_q[0].src;
            if (exp_q[0].due == cyc) begin
                exp_done = 1'b1;
                exp_le   = 24'd1 << exp_q[0].dst;
            end
        end
        chk("busy",       32'(busy),      32'(exp_q.size() != 0));
        chk("EnOut",      32'(EnOut),     32'(exp_en));
        chk("load_en",    32'(load_en),   32'(exp_le));
        chk("done",       32'(done),      32'(exp_done));
        chk("req_ready",  32'(req_ready), 32'(exp_ready));
        chk("err",        32'(err),       32'(exp_err));
        chk("snoop_data", snoop_data,     exp_snoop);
        if (exp_done) begin
`ifdef BUS_SNOOP_EN
            exp_snoop = reg_val(exp_q[0].src);
`endif
            void'(exp_q.pop_front());
        end
    endtask

    task automatic tick(output bit accepted);
        xfer_t x;
        accepted = 1'b0;
        @(posedge clock);
        cyc++;
        if (!clear) begin
            exp_q.delete();
            exp_err   = 1'b0;
            exp_snoop = '0;
            last_due  = -100;
        end else if (req_valid && exp_ready) begin
            accepted = 1'b1;
            if (req_src <= 5'd23 && req_dst <= 5'd23) begin
                x.src    = req_src;
                x.dst    = req_dst;
                x.due    = (cyc + 2 > last_due + 2) ? cyc + 2 : last_due + 2;
                last_due = x.due;
                exp_q.push_back(x);
            end else begin
                exp_err = 1'b1;
            end
        end
        @(negedge clock);
        monitor();
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send(input logic [4:0] s, input logic [4:0] d);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        for (int i = 0; i < 50 && !acc; i++) tick(acc);
        if (!acc) fail_bound("send_accept");
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(acc);
            n++;
        end
        if (exp_q.size() != 0) fail_bound("drain");
        tick(acc);
    endtask

    initial begin
        bit          acc;
        logic [4:0]  b2b_dst [4];
        b2b_dst = '{5'd20, 5'd21, 5'd16, 5'd17};

        clear = 1'b0;
        idle(2);
        clear = 1'b1;

        // Single transfer
        send(5'd5, 5'd9);
        idle(6);

        // Back-to-back transfers
        for (int i = 0; i < 4; i++) send(5'(i), b2b_dst[i]);
        drain();

        // Overfill the queue; later sends stall until a slot frees
        for (int i = 0; i < int'(DEPTH) + 3; i++) send(5'(i + 8), 5'(22 - i));
        drain();

        // Invalid codes are dropped and make err sticky
        send(5'd24, 5'd3);
        idle(3);
        send(5'd7, 5'd7);
        send(5'd2, 5'd30);
        send(5'd23, 5'd0);
        drain();

        // Clear during SELECT with two requests still queued
        for (int i = 0; i < 4; i++) send(5'(i + 1), 5'(i + 10));
        clear = 1'b0;
        idle(1);
        clear = 1'b1;
        idle(3);

        // Random traffic with occasional clears and invalid codes
        for (int i = 0; i < 800; i++) begin
            clear     = ($urandom_range(0, 149) != 0);
            req_valid = ($urandom_range(0, 99) < 65);
            req_src   = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            req_dst   = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            tick(acc);
        end
        clear = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
